// File: rtl/ieeedrv_idcap.sv
// Per-subdrive disk-ID capture: snoops SD buffer writes to the directory sector and latches the 2-byte ID,
// with mount/format overrides, a tick-based timeout fallback and a registered active-drive view.
module ieeedrv_idcap #(
    parameter int         SUBDRV   = 2,
    parameter int         LBA_4040 = 357,
    parameter int         LBA_8250 = 1102,
    parameter logic [7:0] OFS_D    = 8'h18,
    parameter logic [7:0] OFS_G    = 8'hA2,
    parameter int         TMO_W    = 20
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   drv_type,
    input  logic [SUBDRV-1:0]      img_mounted,
    input  logic [2*SUBDRV-1:0]    img_type,
    input  logic [32*SUBDRV-1:0]   sd_lba,
    input  logic [SUBDRV-1:0]      sd_busy,
    input  logic [12:0]            sd_buff_addr,
    input  logic [7:0]             sd_buff_dout,
    input  logic                   sd_buff_wr,
    input  logic                   id_wr,
    input  logic [15:0]            id_hdr,
    input  logic [1:0]             drv_act,
    output logic [16*SUBDRV-1:0]   id,
    output logic [SUBDRV-1:0]      id_loaded,
    output logic [SUBDRV-1:0]      id_tmo,
    output logic [15:0]            id_act,
    output logic                   id_busy_act
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAP,
        ST_VALID
    } state_t;

    localparam logic [TMO_W-1:0] TMO_ALL  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_ALL - TMO_W'(1);

    logic [31:0] dir_lba;
    logic [31:0] sec_ofs;
    logic [7:0]  byte_addr;

    assign dir_lba   = drv_type ? 32'(LBA_4040) : 32'(LBA_8250);
    assign sec_ofs   = {27'd0, sd_buff_addr[12:8]};
    assign byte_addr = sd_buff_addr[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < SUBDRV; gi++) begin : g_sub
            state_t           state_reg;
            logic [TMO_W-1:0] timer_reg;
            logic [15:0]      id_reg;
            logic             loaded_reg;
            logic             tmo_reg;

            logic [31:0]      lba;
            logic [31:0]      lba_sum;
            logic [7:0]       ofs;
            logic [7:0]       ofs_hi;
            logic             hit;
            logic             sel_wr;
            logic             capturing;
            logic             tmo_fire;

            assign lba       = sd_lba[32*gi +: 32];
            assign lba_sum   = lba + sec_ofs;
            assign ofs       = img_type[2*gi+1] ? OFS_G : OFS_D;
            assign ofs_hi    = ofs + 8'd1;
            assign hit       = sd_busy[gi] & sd_buff_wr & (lba_sum == dir_lba);
            assign sel_wr    = id_wr & (drv_act == 2'(gi));
            assign capturing = (state_reg == ST_WAIT) || (state_reg == ST_CAP);
            // The tick that would bring the timer to all ones is the timeout itself.
            assign tmo_fire  = capturing & ce & (timer_reg == TMO_LAST);

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    state_reg  <= ST_IDLE;
                    timer_reg  <= '0;
                    id_reg     <= 16'd0;
                    loaded_reg <= 1'b0;
                    tmo_reg    <= 1'b0;
                end else if (img_mounted[gi]) begin
                    state_reg  <= ST_WAIT;
                    timer_reg  <= '0;
                    loaded_reg <= 1'b0;
                    tmo_reg    <= 1'b0;
                end else if (sel_wr) begin
                    state_reg  <= ST_VALID;
                    timer_reg  <= '0;
                    id_reg     <= id_hdr;
                    loaded_reg <= 1'b1;
                    tmo_reg    <= 1'b0;
                end else if (tmo_fire) begin
                    // Timeout outranks a capture landing in the same cycle.
                    state_reg  <= ST_VALID;
                    timer_reg  <= '0;
                    id_reg     <= 16'd0;
                    loaded_reg <= 1'b1;
                    tmo_reg    <= 1'b1;
                end else if (capturing) begin
                    if (ce) begin
                        timer_reg <= timer_reg + TMO_W'(1);
                    end
                    if (hit) begin
                        if (byte_addr == ofs) begin
                            id_reg[7:0] <= sd_buff_dout;
                            if (state_reg == ST_WAIT) begin
                                state_reg <= ST_CAP;
                            end
                        end
                        if (byte_addr == ofs_hi) begin
                            id_reg[15:8] <= sd_buff_dout;
                        end
                        if (byte_addr == 8'hFF && state_reg == ST_CAP) begin
                            state_reg  <= ST_VALID;
                            timer_reg  <= '0;
                            loaded_reg <= 1'b1;
                        end
                    end
                end
            end

            assign id[16*gi +: 16] = id_reg;
            assign id_loaded[gi]   = loaded_reg;
            assign id_tmo[gi]      = tmo_reg;
        end
    endgenerate

    // Pad the per-subdrive view to the full drv_act range; missing drives read as busy with ID 0.
    logic [15:0] id_pad [4];
    logic [3:0]  busy_pad;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < SUBDRV) begin : g_in
                assign id_pad[gi]   = id[16*gi +: 16];
                assign busy_pad[gi] = ~id_loaded[gi];
            end else begin : g_out
                assign id_pad[gi]   = 16'd0;
                assign busy_pad[gi] = 1'b1;
            end
        end
    endgenerate

    logic [15:0] id_act_reg;
    logic        busy_act_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            id_act_reg   <= 16'd0;
            busy_act_reg <= 1'b0;
        end else begin
            id_act_reg   <= id_pad[drv_act];
            busy_act_reg <= busy_pad[drv_act];
        end
    end

    assign id_act      = id_act_reg;
    assign id_busy_act = busy_act_reg;

endmodule

// File: tb/tb_ieeedrv_idcap.sv
// Bench for ieeedrv_idcap: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the ID capture rules.
module tb_ieeedrv_idcap;

    localparam int TMO_W   = 4;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        drv_type;
    logic [1:0]  img_mounted;
    logic [3:0]  img_type;
    logic [63:0] sd_lba;
    logic [1:0]  sd_busy;
    logic [12:0] sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic        id_wr;
    logic [15:0] id_hdr;
    logic [1:0]  drv_act;
    logic [31:0] id;
    logic [1:0]  id_loaded;
    logic [1:0]  id_tmo;
    logic [15:0] id_act;
    logic        id_busy_act;

    ieeedrv_idcap #(.SUBDRV(2), .TMO_W(TMO_W)) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .drv_type    (drv_type),
        .img_mounted (img_mounted),
        .img_type    (img_type),
        .sd_lba      (sd_lba),
        .sd_busy     (sd_busy),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .id_wr       (id_wr),
        .id_hdr      (id_hdr),
        .drv_act     (drv_act),
        .id          (id),
        .id_loaded   (id_loaded),
        .id_tmo      (id_tmo),
        .id_act      (id_act),
        .id_busy_act (id_busy_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: per subdrive, "waiting" means mounted but no ID yet; low_seen marks
    // that the low ID byte has arrived so the sector end may complete the capture.
    logic [15:0] m_id [2];
    bit          m_loaded [2];
    bit          m_tmo [2];
    bit          m_mounted [2];
    bit          m_low_seen [2];
    int          m_ticks [2];
    logic [15:0] m_act;
    bit          m_busy;

    always @(posedge clk) begin : model
        logic [31:0] dir;
        logic [31:0] sum;
        logic [7:0]  ofs;
        logic [7:0]  bt;
        bit          hit;
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                m_id[s] = 16'd0; m_loaded[s] = 0; m_tmo[s] = 0;
                m_mounted[s] = 0; m_low_seen[s] = 0; m_ticks[s] = 0;
            end
            m_act = 16'd0;
            m_busy = 0;
        end else begin
            if (drv_act < 2) begin
                m_act = m_id[drv_act];
                m_busy = !m_loaded[drv_act];
            end else begin
                m_act = 16'd0;
                m_busy = 1;
            end
            dir = drv_type ? 32'd357 : 32'd1102;
            bt  = sd_buff_addr[7:0];
            for (int s = 0; s < 2; s++) begin
                sum = sd_lba[32*s +: 32] + {27'd0, sd_buff_addr[12:8]};
                hit = sd_busy[s] && sd_buff_wr && (sum == dir);
                ofs = img_type[2*s+1] ? 8'hA2 : 8'h18;
                if (img_mounted[s]) begin
                    m_mounted[s] = 1; m_loaded[s] = 0; m_tmo[s] = 0;
                    m_low_seen[s] = 0; m_ticks[s] = 0;
                end else if (id_wr && drv_act == 2'(s)) begin
                    m_mounted[s] = 1; m_id[s] = id_hdr; m_loaded[s] = 1; m_tmo[s] = 0;
                    m_ticks[s] = 0;
                end else if (m_mounted[s] && !m_loaded[s]) begin
                    if (ce && m_ticks[s] + 1 == TMO_MAX) begin
                        m_id[s] = 16'd0; m_loaded[s] = 1; m_tmo[s] = 1; m_ticks[s] = 0;
                    end else begin
                        if (ce) m_ticks[s]++;
                        if (hit && bt == ofs) begin
                            m_id[s][7:0] = sd_buff_dout;
                            m_low_seen[s] = 1;
                        end
                        if (hit && bt == ofs + 8'd1) m_id[s][15:8] = sd_buff_dout;
                        if (hit && bt == 8'hFF && m_low_seen[s]) begin
                            m_loaded[s] = 1; m_ticks[s] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        check("id",          id,                                  {m_id[1], m_id[0]});
        check("id_loaded",   {30'd0, id_loaded},                  {30'd0, m_loaded[1], m_loaded[0]});
        check("id_tmo",      {30'd0, id_tmo},                     {30'd0, m_tmo[1], m_tmo[0]});
        check("id_act",      {16'd0, id_act},                     {16'd0, m_act});
        check("id_busy_act", {31'd0, id_busy_act},                {31'd0, m_busy});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_byte(input logic [12:0] addr, input logic [7:0] data);
        sd_buff_addr = addr;
        sd_buff_dout = data;
        sd_buff_wr   = 1'b1;
        step();
        sd_buff_wr   = 1'b0;
    endtask

    task automatic pulse_mount(input logic [1:0] m);
        img_mounted = m;
        step();
        img_mounted = 2'b00;
    endtask

    task automatic pulse_idwr(input logic [1:0] act, input logic [15:0] v);
        drv_act = act;
        id_hdr  = v;
        id_wr   = 1'b1;
        step();
        id_wr   = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit do_mount;
        reset_n = 1'b0; ce = 1'b0; drv_type = 1'b1; img_mounted = 2'b00; img_type = 4'b0000;
        sd_lba = 64'd0; sd_busy = 2'b00; sd_buff_addr = 13'd0; sd_buff_dout = 8'd0;
        sd_buff_wr = 1'b0; id_wr = 1'b0; id_hdr = 16'd0; drv_act = 2'd0;
        step(); step();
        check("reset_id",      id, 32'd0);
        check("reset_loaded",  {30'd0, id_loaded}, 32'd0);
        check("reset_busyact", {31'd0, id_busy_act}, 32'd0);
        reset_n = 1'b1;

        // 1: 4040 directory sector on s0
        drv_type = 1'b1; img_type = 4'b0000;
        pulse_mount(2'b01);
        sd_lba[31:0] = 32'd357; sd_busy = 2'b01;
        for (int i = 0; i < 256; i++) begin
            if (i == 8'hFF) check("t1_before_end", {31'd0, id_loaded[0]}, 32'd0);
            wr_byte(13'(i), (i == 'h18) ? 8'h41 : (i == 'h19) ? 8'h42 : 8'($urandom));
        end
        check("t1_id0",     {16'd0, id[15:0]}, 32'h4241);
        check("t1_model",   {16'd0, m_id[0]},  32'h4241);
        check("t1_loaded0", {31'd0, id_loaded[0]}, 32'd1);
        step();
        check("t1_id_act",  {16'd0, id_act}, 32'h4241);

        // 2: 8250, G-type offset on s1, sector offset 2
        drv_type = 1'b0; img_type = 4'b1000; sd_busy = 2'b10;
        pulse_mount(2'b10);
        sd_lba[63:32] = 32'd1100;
        wr_byte(13'h2A2, 8'h31);
        wr_byte(13'h2A3, 8'h32);
        wr_byte(13'h2FF, 8'h00);
        check("t2_id1", {16'd0, id[31:16]}, 32'h3231);
        check("t2_id0", {16'd0, id[15:0]},  32'h4241);
        sd_busy = 2'b00;

        // 3: mount beats id_wr in the same cycle
        img_mounted = 2'b01;
        pulse_idwr(2'd0, 16'h1234);
        img_mounted = 2'b00;
        check("t3_loaded0", {31'd0, id_loaded[0]}, 32'd0);
        check("t3_id0_hold", {16'd0, id[15:0]}, 32'h4241);

        // 4: timeout after TMO_MAX ce ticks
        ce = 1'b1;
        for (int i = 0; i < TMO_MAX - 1; i++) step();
        check("t4_not_yet", {31'd0, id_loaded[0]}, 32'd0);
        step();
        ce = 1'b0;
        check("t4_tmo",    {31'd0, id_tmo[0]},    32'd1);
        check("t4_loaded", {31'd0, id_loaded[0]}, 32'd1);
        check("t4_id0",    {16'd0, id[15:0]},     32'd0);
        pulse_idwr(2'd0, 16'h5A5A);
        check("t4_tmo_clr", {31'd0, id_tmo[0]}, 32'd0);
        check("t4_id_hdr",  {16'd0, id[15:0]}, 32'h5A5A);

        // 5: VALID ignores a rewritten directory sector
        pulse_idwr(2'd0, 16'h4241);
        drv_type = 1'b1; img_type = 4'b1000; sd_lba[31:0] = 32'd357; sd_busy = 2'b01;
        wr_byte(13'h018, 8'h99);
        wr_byte(13'h019, 8'h98);
        wr_byte(13'h0FF, 8'h00);
        check("t5_unchanged", {16'd0, id[15:0]}, 32'h4241);

        // 6: reset mid-capture
        pulse_mount(2'b01);
        wr_byte(13'h018, 8'h77);
        check("t6_low", {24'd0, id[7:0]}, 32'h77);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t6_id",     id, 32'd0);
        check("t6_loaded", {30'd0, id_loaded}, 32'd0);
        check("t6_act",    {16'd0, id_act}, 32'd0);
        sd_busy = 2'b00;

        // Random traffic; after any reset both drives are remounted before snooping resumes.
        do_mount = 1;
        for (int c = 0; c < 4000; c++) begin
            reset_n = 1'b1;
            if ($urandom_range(0, 199) == 0) drv_type = ~drv_type;
            for (int s = 0; s < 2; s++) begin
                logic [31:0] dir;
                dir = drv_type ? 32'd357 : 32'd1102;
                if ($urandom_range(0, 9) == 0)
                    sd_lba[32*s +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : dir - $urandom_range(0, 3);
            end
            img_mounted = do_mount ? 2'b11 : {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)};
            if (img_mounted != 2'b00) img_type = 4'($urandom);
            sd_busy = do_mount ? 2'b00 : 2'($urandom_range(0, 3));
            do_mount = 0;
            ce = ($urandom_range(0, 9) < 3);
            sd_buff_wr = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 6))
                0: sd_buff_addr[7:0] = 8'h18;
                1: sd_buff_addr[7:0] = 8'h19;
                2: sd_buff_addr[7:0] = 8'hA2;
                3: sd_buff_addr[7:0] = 8'hA3;
                4: sd_buff_addr[7:0] = 8'hFF;
                default: sd_buff_addr[7:0] = 8'($urandom);
            endcase
            sd_buff_addr[12:8] = 5'($urandom_range(0, 3));
            sd_buff_dout = 8'($urandom);
            drv_act = 2'($urandom_range(0, 3));
            id_hdr  = 16'($urandom);
            id_wr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                reset_n  = 1'b0;
                do_mount = 1;
            end
            step();
        end
        reset_n = 1'b1; sd_buff_wr = 1'b0; id_wr = 1'b0; img_mounted = 2'b00; ce = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
